// File: rtl/bldc_tick_scheduler_pkg.sv
// ============================================================================
//  Module : bldc_sched_pkg
//  Brief  : Shared types, widths and reset defaults for the BLDC tick scheduler.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bldc_sched_pkg;

    localparam int ESC_W  = 8;
    localparam int CTRL_W = 16;

    localparam logic [ESC_W-1:0]  ESC_DIV_DEF  = 8'd4;
    localparam logic [CTRL_W-1:0] CTRL_DIV_DEF = 16'd25000;
    localparam int                PID_DELAY    = 4;

    localparam int                DLY_W        = $clog2(PID_DELAY + 1);
    localparam logic [CTRL_W-1:0] CTRL_DIV_MIN = CTRL_W'(PID_DELAY + 2);
    localparam logic [7:0]        OVR_CNT_MAX  = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DELAY = 2'd2,
        ST_BUSY  = 2'd3
    } sched_state_t;

    function automatic logic [ESC_W-1:0] clamp_esc_div(input logic [ESC_W-1:0] d);
        return (d == '0) ? ESC_W'(1) : d;
    endfunction

    // A control period must outlast the sample-to-PID delay plus one BUSY cycle.
    function automatic logic [CTRL_W-1:0] clamp_ctrl_div(input logic [CTRL_W-1:0] d);
        return (d < CTRL_DIV_MIN) ? CTRL_DIV_MIN : d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bldc_tick_scheduler_tick_counter.sv
// ============================================================================
//  Module : tick_counter
//  Brief  : Modulo-N counter with synchronous clear, enable and wrap strobe.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tick_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] div,
    output logic         wrap
);

    localparam logic [W-1:0] c_ONE = W'(1);

    logic [W-1:0] r_cnt;

    assign wrap = en && (r_cnt == div - c_ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= wrap ? '0 : r_cnt + c_ONE;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bldc_tick_scheduler.sv
// ============================================================================
//  Module : bldc_tick_scheduler
//  Brief  : Phase-ordered ESC / sample / PID clock-enable strobes with overrun
//           tracking and a valid/ready divisor configuration port.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bldc_tick_scheduler
    import bldc_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ESC_W-1:0]  cfg_esc_div,
    input  logic [CTRL_W-1:0] cfg_ctrl_div,
    input  logic              pid_done,
    output logic              esc_tick,
    output logic              sample_tick,
    output logic              pid_tick,
    output logic              overrun,
    output logic [7:0]        overrun_cnt
);

    localparam logic [DLY_W-1:0] c_DLY_LAST = DLY_W'(PID_DELAY - 1);
    localparam logic [DLY_W-1:0] c_DLY_ONE  = DLY_W'(1);

    sched_state_t      r_state;
    sched_state_t      w_state_nxt;
    logic [ESC_W-1:0]  r_esc_div;
    logic [CTRL_W-1:0] r_ctrl_div;
    logic [DLY_W-1:0]  r_dly_cnt;
    logic [7:0]        r_ovr_cnt;

    logic w_xfer;
    logic w_run;
    logic w_clr;
    logic w_esc_wrap;
    logic w_ctrl_wrap;

    // Ready is gated by rst so every output reads 0 the moment reset asserts.
    assign cfg_ready   = !rst && ((r_state == ST_IDLE) || (r_state == ST_WAIT));
    assign w_xfer      = cfg_valid && cfg_ready;
    assign w_run       = en && (r_state != ST_IDLE) && !w_xfer;
    assign w_clr       = !w_run;
    assign esc_tick    = w_esc_wrap;
    assign overrun_cnt = r_ovr_cnt;

    tick_counter #(.W(ESC_W)) u_esc_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .en   (w_run),
        .div  (r_esc_div),
        .wrap (w_esc_wrap)
    );

    tick_counter #(.W(CTRL_W)) u_ctrl_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .en   (w_run),
        .div  (r_ctrl_div),
        .wrap (w_ctrl_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        sample_tick = 1'b0;
        pid_tick    = 1'b0;
        overrun     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (en) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_ctrl_wrap) begin
                    sample_tick = 1'b1;
                    w_state_nxt = ST_DELAY;
                end
            end
            ST_DELAY: begin
                overrun = w_ctrl_wrap;
                if (w_run && (r_dly_cnt == c_DLY_LAST)) begin
                    pid_tick    = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Completion and a new period in the same cycle: completion wins.
                if (pid_done) begin
                    sample_tick = w_ctrl_wrap;
                    w_state_nxt = w_ctrl_wrap ? ST_DELAY : ST_WAIT;
                end else begin
                    overrun = w_ctrl_wrap;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (!en) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_esc_div  <= ESC_DIV_DEF;
            r_ctrl_div <= CTRL_DIV_DEF;
            r_dly_cnt  <= '0;
            r_ovr_cnt  <= '0;
        end else begin
            if (w_xfer) begin
                r_esc_div  <= clamp_esc_div(cfg_esc_div);
                r_ctrl_div <= clamp_ctrl_div(cfg_ctrl_div);
            end
            if ((r_state == ST_DELAY) && w_run) begin
                r_dly_cnt <= r_dly_cnt + c_DLY_ONE;
            end else begin
                r_dly_cnt <= '0;
            end
            if (overrun && (r_ovr_cnt != OVR_CNT_MAX)) begin
                r_ovr_cnt <= r_ovr_cnt + 8'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bldc_tick_scheduler.sv
// ============================================================================
//  Module : tb_bldc_tick_scheduler
//  Brief  : Self-checking bench for bldc_tick_scheduler against a cycle-count
//           reference model plus literal timing expectations.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_bldc_tick_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [7:0]  cfg_esc_div = 8'd0;
    logic [15:0] cfg_ctrl_div = 16'd0;
    logic        pid_done = 1'b0;
    logic        cfg_ready, esc_tick, sample_tick, pid_tick, overrun;
    logic [7:0]  overrun_cnt;

    bldc_tick_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_esc_div  (cfg_esc_div),
        .cfg_ctrl_div (cfg_ctrl_div),
        .pid_done     (pid_done),
        .esc_tick     (esc_tick),
        .sample_tick  (sample_tick),
        .pid_tick     (pid_tick),
        .overrun      (overrun),
        .overrun_cnt  (overrun_cnt)
    );

    always #20 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int resp_delay = 3;
    int cd = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: run-cycle count since last clear, divisors, and a
    // scheduling phase (0 waiting, 1 delaying, 2 PID busy).
    bit m_active;
    int m_n, m_esc, m_ctrl, m_phase, m_scyc, m_ovc;

    always @(negedge clk) begin : compare
        bit ready, xfer, run, wrap, e_esc, e_smp, e_pid, e_ovr;
        int k;
        if (rst) begin
            chk("rst_cfg_ready", cfg_ready, 0);
            chk("rst_esc", esc_tick, 0);
            chk("rst_sample", sample_tick, 0);
            chk("rst_pid", pid_tick, 0);
            chk("rst_overrun", overrun, 0);
            chk("rst_ovr_cnt", overrun_cnt, 0);
            m_active = 0; m_n = 0; m_esc = 4; m_ctrl = 25000;
            m_phase = 0; m_scyc = -100; m_ovc = 0;
        end else begin
            ready = !m_active || (m_phase == 0);
            xfer  = cfg_valid && ready;
            run   = en && m_active && !xfer;
            k     = m_n + 1;
            e_esc = run && (k % m_esc == 0);
            wrap  = run && (k % m_ctrl == 0);
            e_smp = wrap && ((m_phase == 0) || (m_phase == 2 && pid_done));
            e_ovr = wrap && !e_smp;
            e_pid = run && (m_phase == 1) && (cyc == m_scyc + 4);
            chk("cfg_ready", cfg_ready, ready);
            chk("esc_tick", esc_tick, e_esc);
            chk("sample_tick", sample_tick, e_smp);
            chk("pid_tick", pid_tick, e_pid);
            chk("overrun", overrun, e_ovr);
            chk("overrun_cnt", overrun_cnt, m_ovc);
            if (e_ovr && m_ovc < 255) m_ovc++;
            if (xfer) begin
                m_esc  = (cfg_esc_div == 0) ? 1 : int'(cfg_esc_div);
                m_ctrl = (cfg_ctrl_div < 6) ? 6 : int'(cfg_ctrl_div);
                m_n    = 0;
            end else if (run) begin
                m_n = k;
            end
            if (!en) begin
                m_active = 0; m_n = 0; m_phase = 0;
            end else begin
                m_active = 1;
                if (e_smp) begin
                    m_phase = 1; m_scyc = cyc;
                end else if (e_pid) begin
                    m_phase = 2;
                end else if (m_phase == 2 && pid_done) begin
                    m_phase = 0;
                end
            end
        end
    end

    // PID responder: answers a pid_tick with pid_done resp_delay cycles later.
    always @(negedge clk) if (!rst && pid_tick === 1'b1 && resp_delay > 0) cd = resp_delay;

    task automatic tick();
        @(posedge clk);
        #1;
        pid_done = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) pid_done = 1'b1;
        end
    endtask

    function automatic logic sel(input int w);
        case (w)
            0:       return esc_tick;
            1:       return sample_tick;
            2:       return pid_tick;
            default: return overrun;
        endcase
    endfunction

    task automatic wait_for(input int w, input int budget, input string name, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            #1;
            if (sel(w) === 1'b1) begin
                at = cyc;
                return;
            end
            tick();
        end
        checks++;
        failures++;
        $display("FAIL %s: no strobe within %0d cycles", name, budget);
    endtask

    initial begin : watchdog
        #(90000 * 40);
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int e, at, s, p, w;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_cfg_ready", cfg_ready, 0);
        chk("reset_ovr_cnt", overrun_cnt, 0);
        rst = 1'b0;
        #1;
        chk("idle_cfg_ready", cfg_ready, 1);

        // Defaults: ESC /4, ctrl /25000, PID 4 cycles after sample.
        tick(); en = 1'b1; e = cyc; resp_delay = 3;
        wait_for(0, 10, "t1_esc", at);       chk("t1_first_esc", at - e, 4);
        wait_for(1, 26000, "t1_smp", s);     chk("t1_sample", s - e, 25000);
        wait_for(2, 10, "t1_pid", p);        chk("t1_pid_lat", p - s, 4);
        repeat (5) tick();

        // Reconfigure in WAIT.
        cfg_valid = 1'b1; cfg_esc_div = 8'd2; cfg_ctrl_div = 16'd20; e = cyc;
        #1;
        chk("t2_ready", cfg_ready, 1);
        chk("t2_no_esc_on_xfer", esc_tick, 0);
        tick(); cfg_valid = 1'b0;
        wait_for(0, 10, "t2_esc", at);       chk("t2_first_esc", at - e, 2);
        wait_for(1, 40, "t2_smp", s);        chk("t2_sample", s - e, 20);
        tick(); #1;                          chk("t2_delay_ready", cfg_ready, 0);
        wait_for(2, 10, "t2_pid", p);        chk("t2_pid_lat", p - s, 4);
        tick(); #1;                          chk("t2_busy_ready", cfg_ready, 0);

        // Withheld pid_done -> overruns, saturation.
        wait_for(1, 40, "t3_smp", at);       chk("t3_period", at - s, 20);
        s = at; resp_delay = 0;
        wait_for(3, 40, "t3_ovr", at);       chk("t3_ovr_at", at - s, 20);
        chk("t3_no_sample", sample_tick, 0);
        tick(); #1;                          chk("t3_ovr_cnt1", overrun_cnt, 1);
        repeat (300 * 20) tick();
        #1;                                  chk("t3_ovr_sat", overrun_cnt, 255);

        // pid_done coincident with wrap in BUSY.
        wait_for(3, 40, "t4_ovr", w);
        repeat (20) tick();
        pid_done = 1'b1; resp_delay = 3;
        #1;
        chk("t4_sample", sample_tick, 1);
        chk("t4_no_ovr", overrun, 0);
        tick(); #1;
        chk("t4_delay_ready", cfg_ready, 0);
        chk("t4_ovr_cnt", overrun_cnt, 255);
        wait_for(2, 10, "t4_pid", p);        chk("t4_pid_at", p - w, 24);

        // en dropped on the cycle PID would start.
        wait_for(1, 40, "t5_smp", s);        chk("t5_sample", s - w, 40);
        repeat (4) tick();
        en = 1'b0; #1;                       chk("t5_pid_cancel", pid_tick, 0);
        tick(); #1;
        chk("t5_idle_ready", cfg_ready, 1);
        chk("t5_idle_esc", esc_tick, 0);
        pid_done = 1'b1; #1;                 chk("t5_stray_done", sample_tick, 0);
        tick(); en = 1'b1; e = cyc;
        wait_for(0, 10, "t5_esc", at);       chk("t5_first_esc", at - e, 2);
        wait_for(1, 40, "t5_smp2", s);       chk("t5_sample2", s - e, 20);

        // Async reset in BUSY, then clamped configuration.
        resp_delay = 0;
        wait_for(2, 10, "t6_pid", p);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_esc", esc_tick, 0);
        chk("t6_rst_smp", sample_tick, 0);
        chk("t6_rst_pid", pid_tick, 0);
        chk("t6_rst_ovr", overrun, 0);
        chk("t6_rst_cnt", overrun_cnt, 0);
        chk("t6_rst_ready", cfg_ready, 0);
        tick(); tick(); rst = 1'b0; e = cyc;
        wait_for(0, 10, "t6_esc", at);       chk("t6_def_esc", at - e, 4);
        wait_for(1, 26000, "t6_smp", s);     chk("t6_def_ctrl", s - e, 25000);
        tick(); en = 1'b0;
        tick(); cfg_valid = 1'b1; cfg_esc_div = 8'd0; cfg_ctrl_div = 16'd3;
        tick(); cfg_valid = 1'b0; en = 1'b1; e = cyc; resp_delay = 1;
        wait_for(0, 10, "t6_esc1", at);      chk("t6_esc_clamp", at - e, 1);
        wait_for(1, 20, "t6_smp1", s);       chk("t6_ctrl_clamp", s - e, 6);
        tick();
        wait_for(1, 20, "t6_smp2", at);      chk("t6_ctrl_period", at - s, 6);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            tick();
            if ($urandom_range(0, 299) == 0) en = ~en;
            if (!en && $urandom_range(0, 2) == 0) en = 1'b1;
            if ($urandom_range(0, 59) == 0) begin
                cfg_valid    = 1'b1;
                cfg_esc_div  = 8'($urandom_range(0, 5));
                cfg_ctrl_div = 16'($urandom_range(0, 40));
            end else begin
                cfg_valid = 1'b0;
            end
            if ($urandom_range(0, 24) == 0) pid_done = 1'b1;
            if ($urandom_range(0, 19) == 0) resp_delay = $urandom_range(0, 25);
        end
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
